// File: rtl/pid_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : pid_cmd_decoder
// Purpose : Byte-stream W/R command decoder driving the PID register file.
// Rev     : 1.0  initial release
// ============================================================================
module pid_cmd_decoder #(
    parameter int         MAX_ADDR       = 15,
    parameter int         RO_LO          = 14,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [7:0] r_data_i,
    input  logic       tx_ready,
    output logic       write_enable,
    output logic [7:0] w_addr,
    output logic [7:0] w_data,
    output logic [7:0] r_addr,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam logic [7:0] c_OP_WRITE = 8'h57;
    localparam logic [7:0] c_OP_READ  = 8'h52;
    localparam int         c_TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_MAX_ADDR = 8'(MAX_ADDR);
    localparam logic [7:0] c_RO_LO    = 8'(RO_LO);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_WRITE    = 3'd3,
        S_RD_WAIT1 = 3'd4,
        S_RD_WAIT2 = 3'd5,
        S_SEND     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [7:0]         w_addr_q, w_addr_d;
    logic [7:0]         w_data_q, w_data_d;
    logic [7:0]         r_addr_q, r_addr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [7:0]         err_q, err_d;
    logic [c_TMO_W-1:0] tmo_q, tmo_d;
    logic               w_err_inc;
    logic               w_addr_bad;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            w_addr_q   <= 8'h00;
            w_data_q   <= 8'h00;
            r_addr_q   <= 8'h00;
            tx_data_q  <= 8'h00;
            err_q      <= 8'h00;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            r_addr_q   <= r_addr_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        r_addr_d   = r_addr_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        w_err_inc  = 1'b0;
        w_addr_bad = (rx_data > c_MAX_ADDR) || (is_write_q && (rx_data >= c_RO_LO));

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == c_OP_WRITE) || (rx_data == c_OP_READ)) begin
                        is_write_d = (rx_data == c_OP_WRITE);
                        state_d    = S_GET_ADDR;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        w_err_inc = 1'b1;
                        state_d   = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    if (w_addr_bad) begin
                        tx_data_d = NAK_BYTE;
                        w_err_inc = 1'b1;
                        state_d   = S_SEND;
                    end else if (is_write_q) begin
                        w_addr_d = rx_data;
                        state_d  = S_GET_DATA;
                    end else begin
                        r_addr_d = rx_data;
                        state_d  = S_RD_WAIT1;
                    end
                end else if (tmo_q == c_TMO_LAST) begin
                    w_err_inc = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GET_DATA: begin
                if (rx_valid) begin
                    w_data_d = rx_data;
                    state_d  = S_WRITE;
                end else if (tmo_q == c_TMO_LAST) begin
                    w_err_inc = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                tx_data_d = ACK_BYTE;
                state_d   = S_SEND;
            end
            S_RD_WAIT1: begin
                state_d = S_RD_WAIT2;
            end
            S_RD_WAIT2: begin
                // Register file read data is valid one cycle after r_addr settles.
                tx_data_d = r_data_i;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tmo_d = '0;
        end
        if (w_err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Strobe decoded from state so an asynchronous reset drops it immediately.
    assign write_enable = (state_q == S_WRITE);
    assign tx_valid     = (state_q == S_SEND);
    assign busy         = (state_q != S_IDLE);
    assign w_addr       = w_addr_q;
    assign w_data       = w_data_q;
    assign r_addr       = r_addr_q;
    assign tx_data      = tx_data_q;
    assign err_count    = err_q;

endmodule
`default_nettype wire
